// File: rtl/jtgng_prom_loader_pkg.sv
// Game-wide PROM download map: region constants, bank roles and loader state encoding.
package jtgng_prom_loader_pkg;

    localparam int          AW         = 22;
    localparam logic [21:0] PROM_START = 22'h1_C000;
    localparam int          NPROM      = 8;
    localparam int          PROM_AW    = 8;
    localparam int          DW         = 4;

    localparam int BW = $clog2(NPROM);   // bank-select bits
    localparam int OW = PROM_AW + BW;    // offset bits spanning the whole region
    localparam int CW = OW + 1;          // write counter, one extra bit to hold "full"

    localparam logic [CW-1:0] CNT_FULL = CW'(NPROM << PROM_AW);

    // Bank roles in download order
    localparam int BANK_RED    = 0;
    localparam int BANK_GREEN  = 1;
    localparam int BANK_BLUE   = 2;
    localparam int BANK_CHAR   = 3;
    localparam int BANK_OBJ    = 4;
    localparam int BANK_OBJ_HI = 5;
    localparam int BANK_PRIO   = 6;
    localparam int BANK_TIMING = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/jtgng_prom_loader_if.sv
// Download-stream input and PROM write-port output bundle, plus loader debug taps.
// Handshake: one byte is transferred on every clk where ioctl_wr=1 (no back-pressure);
// prom_we is a one-cycle strobe qualifying prom_addr/prom_data, which hold between strobes.
interface jtgng_prom_loader_if;
    import jtgng_prom_loader_pkg::*;

    logic                downloading;
    logic [AW-1:0]       ioctl_addr;
    logic [7:0]          ioctl_data;
    logic                ioctl_wr;

    logic [NPROM-1:0]    prom_we;
    logic [PROM_AW-1:0]  prom_addr;
    logic [DW-1:0]       prom_data;
    logic                loaded;
    logic                done;
    logic                err;

    loader_state_t       state;
    logic [CW-1:0]       cnt;

    modport master (
        output downloading, ioctl_addr, ioctl_data, ioctl_wr,
        input  prom_we, prom_addr, prom_data, loaded, done, err, state, cnt
    );

    modport slave (
        input  downloading, ioctl_addr, ioctl_data, ioctl_wr,
        output prom_we, prom_addr, prom_data, loaded, done, err, state, cnt
    );

endinterface

// File: rtl/jtgng_prom_decode.sv
// Combinational region decode: in-region flag, bank one-hot, region offset and entry address.
module jtgng_prom_decode
    import jtgng_prom_loader_pkg::*;
(
    input  logic [AW-1:0]      addr,
    output logic               in_region,
    output logic [NPROM-1:0]   bank_oh,
    output logic [OW-1:0]      off,
    output logic [PROM_AW-1:0] entry
);

    localparam logic [63:0] REGION = 64'(NPROM) << PROM_AW;

    logic [AW-1:0] full_off;

    always_comb begin
        full_off  = addr - PROM_START;
        // the lower-bound test catches addresses that wrapped around in the subtraction
        in_region = (addr >= PROM_START) && ({{(64-AW){1'b0}}, full_off} < REGION);
        off       = full_off[OW-1:0];
        entry     = off[PROM_AW-1:0];
        bank_oh   = '0;
        bank_oh[off[OW-1:PROM_AW]] = in_region;
    end

endmodule

// File: rtl/jtgng_prom_loader.sv
// Routes download bytes in the PROM region to per-bank write strobes and tracks fill progress.
module jtgng_prom_loader
    import jtgng_prom_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    jtgng_prom_loader_if.slave bus
);

    logic               in_region;
    logic [NPROM-1:0]   bank_oh;
    logic [OW-1:0]      off;
    logic [PROM_AW-1:0] entry;

    loader_state_t      state;
    logic [CW-1:0]      cnt;
    logic [OW:0]        exp_off;
    logic [NPROM-1:0]   prom_we;
    logic [PROM_AW-1:0] prom_addr;
    logic [DW-1:0]      prom_data;
    logic               loaded;
    logic               done;
    logic               err;
    logic               accept;

    jtgng_prom_decode u_decode (
        .addr      (bus.ioctl_addr),
        .in_region (in_region),
        .bank_oh   (bank_oh),
        .off       (off),
        .entry     (entry)
    );

    assign accept = (state == LOAD) && bus.ioctl_wr && in_region;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            exp_off   <= '0;
            prom_we   <= '0;
            prom_addr <= '0;
            prom_data <= '0;
            loaded    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            prom_we <= '0;
            done    <= 1'b0;

            // a byte taken on the last LOAD cycle still strobes while in DONE
            if (accept) begin
                prom_we   <= bank_oh;
                prom_addr <= entry;
                prom_data <= bus.ioctl_data[DW-1:0];
                if (~&cnt) cnt <= cnt + 1'b1;
                if ({1'b0, off} != exp_off) err <= 1'b1;
                exp_off   <= {1'b0, off} + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.downloading) begin
                        state   <= LOAD;
                        cnt     <= '0;
                        exp_off <= '0;
                        loaded  <= 1'b0;
                        err     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (!bus.downloading) state <= DONE;
                end
                DONE: begin
                    // cnt and err already include any byte from the final LOAD cycle
                    done   <= 1'b1;
                    loaded <= (cnt == CNT_FULL) && !err;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.state     = state;
    assign bus.cnt       = cnt;
    assign bus.prom_we   = prom_we;
    assign bus.prom_addr = prom_addr;
    assign bus.prom_data = prom_data;
    assign bus.loaded    = loaded;
    assign bus.done      = done;
    assign bus.err       = err;

endmodule

// File: tb/tb_jtgng_prom_loader.sv
// Directed-sequence bench for jtgng_prom_loader with randomized data, gaps and stray bytes.
module tb_jtgng_prom_loader;
    import jtgng_prom_loader_pkg::*;

    localparam int START  = 32'h1_C000;
    localparam int REGION = 2048;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jtgng_prom_loader_if bus();

    jtgng_prom_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // reference model state
    bit ref_active;
    int ref_cnt;
    int ref_next;
    bit ref_err;
    int ref_addr;
    int ref_data;
    logic [7:0] last_we;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Called just after a negedge; applies a byte, checks the strobe one clk later, then idles.
    task automatic send_byte(input int a, input logic [7:0] d, input int gap, input bit drop);
        int  off;
        bit  hit;
        logic [7:0] exp_we;
        off = a - START;
        hit = ref_active && (a >= START) && (off < REGION);
        bus.ioctl_addr = 22'(a);
        bus.ioctl_data = d;
        bus.ioctl_wr   = 1'b1;
        if (drop) bus.downloading = 1'b0;
        @(negedge clk);
        bus.ioctl_wr = 1'b0;
        exp_we = 8'h00;
        if (hit) begin
            exp_we   = 8'(1 << (off / 256));
            ref_addr = off % 256;
            ref_data = int'(d) % 16;
            if (ref_cnt < 4095) ref_cnt++;
            if (off != ref_next) ref_err = 1'b1;
            ref_next = off + 1;
        end
        last_we = bus.prom_we;
        check("prom_we",   32'(bus.prom_we),   32'(exp_we));
        check("prom_addr", 32'(bus.prom_addr), 32'(ref_addr));
        check("prom_data", 32'(bus.prom_data), 32'(ref_data));
        check("cnt",       32'(bus.cnt),       32'(ref_cnt));
        check("err",       32'(bus.err),       32'(ref_err));
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("we_idle", 32'(bus.prom_we), 32'h0);
        end
    endtask

    task automatic start_dl(input bit with_wr);
        bus.downloading = 1'b1;
        if (with_wr) begin
            bus.ioctl_addr = 22'(START);
            bus.ioctl_data = 8'($urandom);
            bus.ioctl_wr   = 1'b1;
        end
        @(negedge clk);
        bus.ioctl_wr = 1'b0;
        ref_active = 1'b1;
        ref_cnt    = 0;
        ref_next   = 0;
        ref_err    = 1'b0;
        check("start_state",  32'(bus.state),   32'(LOAD));
        check("start_we",     32'(bus.prom_we), 32'h0);
        check("start_cnt",    32'(bus.cnt),     32'h0);
        check("start_loaded", 32'(bus.loaded),  32'h0);
        check("start_err",    32'(bus.err),     32'h0);
        @(negedge clk);
    endtask

    // Expects the DUT to be in DONE at the current negedge.
    task automatic finish_dl();
        bit exp_loaded;
        ref_active = 1'b0;
        exp_loaded = (ref_cnt == REGION) && !ref_err;
        check("done_state", 32'(bus.state), 32'(DONE));
        check("done_early", 32'(bus.done),  32'h0);
        @(negedge clk);
        check("done_pulse", 32'(bus.done),   32'h1);
        check("loaded",     32'(bus.loaded), 32'(exp_loaded));
        check("err_final",  32'(bus.err),    32'(ref_err));
        check("idle_state", 32'(bus.state),  32'(IDLE));
        @(negedge clk);
        check("done_once",  32'(bus.done),   32'h0);
        check("loaded_hold", 32'(bus.loaded), 32'(exp_loaded));
    endtask

    task automatic end_dl();
        bus.downloading = 1'b0;
        @(negedge clk);
        finish_dl();
    endtask

    function automatic int stray_addr();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, START - 1));
        return int'($urandom_range(START + REGION, 32'h3F_FFFF));
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.downloading = 1'b0;
        bus.ioctl_addr  = '0;
        bus.ioctl_data  = '0;
        bus.ioctl_wr    = 1'b0;
        ref_active = 1'b0;
        ref_cnt = 0; ref_next = 0; ref_err = 1'b0; ref_addr = 0; ref_data = 0;

        // reset
        repeat (3) @(negedge clk);
        check("rst_we",     32'(bus.prom_we),   32'h0);
        check("rst_addr",   32'(bus.prom_addr), 32'h0);
        check("rst_data",   32'(bus.prom_data), 32'h0);
        check("rst_loaded", 32'(bus.loaded),    32'h0);
        check("rst_done",   32'(bus.done),      32'h0);
        check("rst_err",    32'(bus.err),       32'h0);
        check("rst_state",  32'(bus.state),     32'(IDLE));
        check("rst_cnt",    32'(bus.cnt),       32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // write while not downloading is ignored
        send_byte(START, 8'hA7, 2, 1'b0);
        check("idle_wr_state", 32'(bus.state), 32'(IDLE));

        // full in-order download with surrounding out-of-region bytes, data = addr[7:0]
        start_dl(1'b1);
        for (int a = START - 256; a < START + REGION + 256; a++) begin
            send_byte(a, 8'(a), $urandom_range(1, 3), 1'b0);
            if (a == 32'h1_C305) begin
                check("we_1c305",   32'(last_we),       32'h08);
                check("addr_1c305", 32'(bus.prom_addr), 32'h05);
                check("data_1c305", 32'(bus.prom_data), 32'h5);
            end
        end
        end_dl();

        // swapped pair 0x1C010/0x1C011 with random stray bytes
        start_dl(1'b0);
        for (int i = 0; i < REGION; i++) begin
            int a;
            a = START + ((i == 16) ? 17 : (i == 17) ? 16 : i);
            if ($urandom_range(0, 7) == 0) send_byte(stray_addr(), 8'($urandom), 1, 1'b0);
            send_byte(a, 8'($urandom), $urandom_range(1, 3), 1'b0);
            if (i == 16) check("err_at_swap", 32'(bus.err), 32'h1);
        end
        end_dl();

        // cancelled download: last byte 0x1C3FF arrives on the final LOAD cycle
        start_dl(1'b0);
        for (int a = START; a < START + 1023; a++) send_byte(a, 8'($urandom), $urandom_range(1, 3), 1'b0);
        send_byte(START + 1023, 8'($urandom), 0, 1'b1);
        finish_dl();

        // full re-download restores loaded
        start_dl(1'b0);
        for (int a = START; a < START + REGION; a++) send_byte(a, 8'($urandom), $urandom_range(1, 3), 1'b0);
        end_dl();

        // reset in the middle of a download, aligned with byte 0x1C200
        start_dl(1'b0);
        for (int a = START; a < START + 512; a++) send_byte(a, 8'($urandom), $urandom_range(1, 3), 1'b0);
        bus.ioctl_addr  = 22'h1_C200;
        bus.ioctl_data  = 8'($urandom);
        bus.ioctl_wr    = 1'b1;
        bus.downloading = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        bus.ioctl_wr = 1'b0;
        rst_n = 1'b1;
        ref_active = 1'b0;
        check("mid_rst_we",     32'(bus.prom_we),   32'h0);
        check("mid_rst_addr",   32'(bus.prom_addr), 32'h0);
        check("mid_rst_data",   32'(bus.prom_data), 32'h0);
        check("mid_rst_loaded", 32'(bus.loaded),    32'h0);
        check("mid_rst_done",   32'(bus.done),      32'h0);
        check("mid_rst_err",    32'(bus.err),       32'h0);
        check("mid_rst_cnt",    32'(bus.cnt),       32'h0);
        check("mid_rst_state",  32'(bus.state),     32'(IDLE));
        @(negedge clk);
        check("post_rst_we",    32'(bus.prom_we),   32'h0);
        check("post_rst_state", 32'(bus.state),     32'(IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtgng_prom_loader.md
Name: jtgng_prom_loader

Overview:
- Write-side companion to the PROM blocks: turns the ROM-download byte stream (ioctl_addr/ioctl_data/ioctl_wr while downloading) into per-PROM write strobes, write address and write data.
- Sits between the top-level downloader and the colour, sprite and timing PROMs.
- Tracks fill progress, flags out-of-order streams, and reports when every PROM has been completely written.

Parameters:
- AW, 22, ioctl address width.
- PROM_START, 22'h1_C000, first download byte belonging to PROM bank 0.
- NPROM, 8, number of PROM banks; each bank is PROM_AW deep.
- PROM_AW, 8, address width of each PROM (2**PROM_AW entries).
- DW, 4, PROM data width; taken from ioctl_data[DW-1:0].

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- downloading  in  1  download in progress (level).
- ioctl_addr  in  AW  byte address of the current download byte.
- ioctl_data  in  8  download byte.
- ioctl_wr  in  1  byte-valid strobe, one clk wide, at least 2 clk apart.
- prom_we  out  NPROM  one-hot write strobe, one bit per bank.
- prom_addr  out  PROM_AW  write address shared by all banks.
- prom_data  out  DW  write data shared by all banks.
- loaded  out  1  all NPROM<<PROM_AW entries written, in order, during the last download.
- done  out  1  one-cycle pulse at the end of each download.
- err  out  1  sticky flag: out-of-order address seen inside the PROM region.

Behaviour:
- Reset (rst_n=0 at a clk edge) forces:
  - all outputs to 0;
  - the state machine to IDLE;
  - cnt and expected offset to 0.
  - Reset during LOAD abandons the download; no strobe is issued on the reset cycle or the cycle after it.
- Region decode: off = ioctl_addr - PROM_START, computed at AW bits.
  - A byte is in region when ioctl_addr >= PROM_START and off < NPROM<<PROM_AW.
  - bank = off[PROM_AW+clog2(NPROM)-1:PROM_AW].
  - Entry address = off[PROM_AW-1:0].
- State machine:
  - IDLE: waiting for a download. Goes to LOAD on the cycle downloading is sampled 1.
    - On entry to LOAD, clear cnt, the expected offset, loaded and err.
  - LOAD: accepts bytes. Goes to DONE on the cycle downloading is sampled 0.
  - DONE: asserts done for exactly one cycle.
    - Sets loaded = (cnt == NPROM<<PROM_AW) && !err.
    - Then goes to IDLE.
- Write path, while in LOAD:
  - ioctl_wr with an in-region address, sampled at edge N: at edge N+1 prom_we[bank] goes high for exactly one cycle.
  - prom_addr/prom_data are updated at that same edge and held until the next accepted write.
  - Latency is 1 clk, registered.
  - Out-of-region bytes cause no strobe, no counter change and no error.
- ioctl_wr is ignored in IDLE and DONE, including when downloading and ioctl_wr rise on the same cycle.
- Ordering check: each in-region byte compares off against the expected offset.
  - On mismatch, set err (sticky until the next LOAD entry) but still perform the write.
  - Expected offset becomes off+1 after every in-region write.
- cnt counts in-region writes. It is PROM_AW+clog2(NPROM)+1 bits wide and saturates at all-ones; no wrap-around.
- ioctl_data[7:DW] is discarded.
- Only one prom_we bit is ever high; prom_we is never high outside LOAD+1 cycle timing.
- A byte accepted on the last LOAD cycle still produces its strobe, concurrent with the DONE cycle.
- Cancelled download: if downloading falls with a partial count, loaded=0 and done still pulses.
- Re-download: restarts fully from IDLE→LOAD and clears loaded.

Decomposition:
- Shared package holds:
  - the region constants PROM_START, NPROM and PROM_AW per game;
  - bank index definitions (e.g. colour R/G/B, char LUT, obj LUT, timing);
  - the state encoding typedef (IDLE, LOAD, DONE).
- One natural sub-module, jtgng_prom_decode: combinational in-region test, bank one-hot and entry address from ioctl_addr.
- Sequencing, counters and flags stay in the top.

Test Plan (PROM_START=22'h1C000, NPROM=8, PROM_AW=8; region 0x1C000–0x1C7FF):
- Full in-order download of 0x0000–0x1C7FF, ioctl_wr every 4 clk, data=addr[7:0] -> 2048 strobes.
  - Byte 0x1C305 gives prom_we=8'h08, prom_addr=8'h05, prom_data=4'h5 one clk after ioctl_wr.
  - done pulses once; loaded=1; err=0.
- Bytes below 0x1C000 and above 0x1C7FF -> prom_we stays 0 and cnt is unchanged.
- Swap bytes 0x1C010 and 0x1C011 -> both written; err=1 after the first mismatch; loaded=0 at done.
- downloading drops after 0x1C3FF -> done pulses; loaded=0; err=0. A following full download then gives loaded=1.
- rst_n=0 mid-LOAD at byte 0x1C200 -> next cycle all outputs 0; the pending strobe is suppressed; state is IDLE.
- ioctl_wr asserted with downloading=0 at address 0x1C000 -> no strobe, no state change.
